// File: rtl/pci_rr_arbiter.sv
// Round-robin PCI bus arbiter: registered active-low grants, grant timeout, bus-idle tracking.
// Define PCI_ARB_PARK_EN to park the idle bus on PARK_MASTER.
module pci_rr_arbiter #(
  parameter int N_MASTERS   = 5,
  parameter int OWNER_W     = 3,
  parameter int GNT_TIMEOUT = 16,
  parameter int PARK_MASTER = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req_n,
  output logic [N_MASTERS-1:0] gnt_n,
  input  logic                 frame_n,
  input  logic                 irdy_n,
  output logic [OWNER_W-1:0]   bus_owner,
  output logic                 owner_valid,
  output logic                 timeout_pulse
);

  localparam int IDX_W = $clog2(N_MASTERS);
  // One spare count so timer + 1 can reach GNT_TIMEOUT without wrapping.
  localparam int TMR_W = $clog2(GNT_TIMEOUT + 2);
  localparam logic [TMR_W-1:0]   TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0]   TMR_LIMIT = TMR_W'(GNT_TIMEOUT);
  localparam logic [OWNER_W-1:0] LAST_RST  = OWNER_W'(N_MASTERS - 1);

  if (PARK_MASTER < 0 || PARK_MASTER >= N_MASTERS || (2 ** OWNER_W) < N_MASTERS) begin : g_bad_cfg
    $error("pci_rr_arbiter: invalid N_MASTERS/OWNER_W/PARK_MASTER combination");
  end

`ifdef PCI_ARB_PARK_EN
  localparam logic [OWNER_W-1:0]   PARK_IDX  = OWNER_W'(PARK_MASTER);
  localparam logic [N_MASTERS-1:0] PARK_MASK = N_MASTERS'(1) << PARK_MASTER;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNTD = 2'd1,
`ifdef PCI_ARB_PARK_EN
    BUSY = 2'd2,
    PARK = 2'd3
`else
    BUSY = 2'd2
`endif
  } state_t;

  state_t                 state, state_d;
  logic [N_MASTERS-1:0]   req;
  logic [N_MASTERS-1:0]   gnt_d;
  logic [OWNER_W-1:0]     owner_d;
  logic [OWNER_W-1:0]     last, last_d;
  logic [OWNER_W-1:0]     winner;
  logic                   valid_d;
  logic                   tmo_d;
  logic                   bus_idle;
  logic [TMR_W-1:0]       timer, timer_d, timer_inc;

  // First requester after 'last', wrapping; the closest candidate is evaluated last and wins.
  function automatic logic [OWNER_W-1:0] rr_pick(input logic [N_MASTERS-1:0] r,
                                                 input logic [OWNER_W-1:0]   lst);
    logic [OWNER_W-1:0] pick;
    logic [IDX_W-1:0]   sel;
    pick = '0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      sel = IDX_W'((int'(lst) + k) % N_MASTERS);
      if (r[sel]) pick = OWNER_W'(sel);
    end
    return pick;
  endfunction

  function automatic logic [N_MASTERS-1:0] grant_vec(input logic [OWNER_W-1:0] idx);
    logic [N_MASTERS-1:0] v;
    v = '1;
    v[IDX_W'(idx)] = 1'b0;
    return v;
  endfunction

  assign req       = ~req_n;
  assign bus_idle  = frame_n & irdy_n;
  assign winner    = rr_pick(req, last);
  assign timer_inc = timer + TMR_ONE;

  always_comb begin
    state_d = state;
    gnt_d   = gnt_n;
    owner_d = bus_owner;
    valid_d = owner_valid;
    tmo_d   = 1'b0;
    timer_d = timer;
    last_d  = last;
    case (state)
      IDLE: begin
        if (|req) begin
          state_d = GNTD;
          gnt_d   = grant_vec(winner);
          owner_d = winner;
          valid_d = 1'b1;
          timer_d = '0;
        end
`ifdef PCI_ARB_PARK_EN
        else begin
          state_d = PARK;
          gnt_d   = grant_vec(PARK_IDX);
          owner_d = PARK_IDX;
          valid_d = 1'b1;
        end
`endif
      end
      GNTD: begin
        // Timeout outranks a frame_n seen on the same edge.
        if ((GNT_TIMEOUT != 0) && (timer_inc == TMR_LIMIT)) begin
          state_d = IDLE;
          gnt_d   = '1;
          valid_d = 1'b0;
          tmo_d   = 1'b1;
          last_d  = bus_owner;
        end else if (!frame_n) begin
          state_d = BUSY;
          last_d  = bus_owner;
        end else if (!req[IDX_W'(bus_owner)]) begin
          state_d = IDLE;
          gnt_d   = '1;
          valid_d = 1'b0;
        end else begin
          timer_d = timer_inc;
        end
      end
      BUSY: begin
        if (bus_idle) begin
          state_d = IDLE;
          gnt_d   = '1;
          valid_d = 1'b0;
        end
      end
`ifdef PCI_ARB_PARK_EN
      PARK: begin
        if ((req & ~PARK_MASK) != '0) begin
          state_d = IDLE;
          gnt_d   = '1;
          valid_d = 1'b0;
        end else if (req[IDX_W'(PARK_IDX)]) begin
          state_d = GNTD;
          timer_d = '0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        gnt_d   = '1;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      gnt_n         <= '1;
      bus_owner     <= '0;
      owner_valid   <= 1'b0;
      timeout_pulse <= 1'b0;
      last          <= LAST_RST;
      timer         <= '0;
    end else begin
      state         <= state_d;
      gnt_n         <= gnt_d;
      bus_owner     <= owner_d;
      owner_valid   <= valid_d;
      timeout_pulse <= tmo_d;
      last          <= last_d;
      timer         <= timer_d;
    end
  end

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Directed scoreboard bench for pci_rr_arbiter (N_MASTERS=5, GNT_TIMEOUT=4, PARK_MASTER=0).
// Follows PCI_ARB_PARK_EN the same way as the design.
module tb_pci_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [4:0] req_n;
  logic [4:0] gnt_n;
  logic       frame_n;
  logic       irdy_n;
  logic [2:0] bus_owner;
  logic       owner_valid;
  logic       timeout_pulse;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0] gnt;
    logic       valid;
    logic [2:0] owner;
    logic       tmo;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  pci_rr_arbiter #(
    .N_MASTERS  (5),
    .OWNER_W    (3),
    .GNT_TIMEOUT(4),
    .PARK_MASTER(0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_n        (req_n),
    .gnt_n        (gnt_n),
    .frame_n      (frame_n),
    .irdy_n       (irdy_n),
    .bus_owner    (bus_owner),
    .owner_valid  (owner_valid),
    .timeout_pulse(timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of bus inputs, queue what the grant outputs must be after the edge, then check.
  task automatic step(input logic [4:0] r, input logic f, input logic i,
                      input logic [4:0] eg, input logic ev, input logic [2:0] eo,
                      input logic et, input string tag);
    exp_t e;
    req_n   = r;
    frame_n = f;
    irdy_n  = i;
    e.gnt = eg; e.valid = ev; e.owner = eo; e.tmo = et; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({e.tag, ".gnt"},   32'(gnt_n),         32'(e.gnt));
    chk({e.tag, ".valid"}, 32'(owner_valid),   32'(e.valid));
    chk({e.tag, ".tmo"},   32'(timeout_pulse), 32'(e.tmo));
    if (e.valid || rst) chk({e.tag, ".owner"}, 32'(bus_owner), 32'(e.owner));
    chk({e.tag, ".onehot"}, 32'($countones(~gnt_n) <= 1), 32'(1));
    @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    req_n   = 5'b00000;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    @(negedge clk);

    // Reset holds everything released even with all masters requesting.
    for (int k = 0; k < 3; k++) step(5'b00000, 1, 1, 5'b11111, 0, 3'd0, 0, "reset");
    rst = 1'b0;
    step(5'b00000, 1, 1, 5'b11110, 1, 3'd0, 0, "first_grant");

    // Round-robin between masters 0 and 1, two frame cycles per transaction.
    step(5'b11100, 0, 1, 5'b11110, 1, 3'd0, 0, "rr0_busy");
    step(5'b11100, 0, 1, 5'b11110, 1, 3'd0, 0, "rr0_hold");
    step(5'b11100, 1, 1, 5'b11111, 0, 3'd0, 0, "rr0_turn");
    step(5'b11100, 1, 1, 5'b11101, 1, 3'd1, 0, "rr1_grant");
    step(5'b11100, 0, 1, 5'b11101, 1, 3'd1, 0, "rr1_busy");
    step(5'b11100, 0, 1, 5'b11101, 1, 3'd1, 0, "rr1_hold");
    step(5'b11100, 1, 1, 5'b11111, 0, 3'd1, 0, "rr1_turn");
    step(5'b11100, 1, 1, 5'b11110, 1, 3'd0, 0, "rr2_grant");
    step(5'b11100, 0, 1, 5'b11110, 1, 3'd0, 0, "rr2_busy");
    step(5'b11100, 0, 1, 5'b11110, 1, 3'd0, 0, "rr2_hold");
    step(5'b11100, 1, 1, 5'b11111, 0, 3'd0, 0, "rr2_turn");
    step(5'b11100, 1, 1, 5'b11101, 1, 3'd1, 0, "rr3_grant");

    // Master 1 keeps the bus through its last data phase while master 0 waits.
    step(5'b11100, 0, 1, 5'b11101, 1, 3'd1, 0, "busy_enter");
    step(5'b11100, 0, 0, 5'b11101, 1, 3'd1, 0, "busy_data");
    step(5'b11100, 1, 0, 5'b11101, 1, 3'd1, 0, "busy_last");
    step(5'b11100, 1, 1, 5'b11111, 0, 3'd1, 0, "busy_rel");
    step(5'b11100, 1, 1, 5'b11110, 1, 3'd0, 0, "busy_next");

    // Master 0 withdraws; master 2 is granted and never starts a frame.
    step(5'b11011, 1, 1, 5'b11111, 0, 3'd0, 0, "wd0_rel");
    step(5'b11011, 1, 1, 5'b11011, 1, 3'd2, 0, "to_grant");
    step(5'b11011, 1, 1, 5'b11011, 1, 3'd2, 0, "to_wait1");
    step(5'b11011, 1, 1, 5'b11011, 1, 3'd2, 0, "to_wait2");
    step(5'b11011, 1, 1, 5'b11011, 1, 3'd2, 0, "to_wait3");
    step(5'b11011, 1, 1, 5'b11111, 0, 3'd2, 1, "to_fire");
    // Master 2 lost its turn: masters 2,3,4 request and 3 wins.
    step(5'b00011, 1, 1, 5'b10111, 1, 3'd3, 0, "to_next");

    // Master 3 withdraws before framing; pointer stays at 2 so 3 wins again.
    step(5'b00011, 1, 1, 5'b10111, 1, 3'd3, 0, "wd3_wait");
    step(5'b01011, 1, 1, 5'b11111, 0, 3'd3, 0, "wd3_rel");
    step(5'b00011, 1, 1, 5'b10111, 1, 3'd3, 0, "wd3_regrant");
    step(5'b11111, 1, 1, 5'b11111, 0, 3'd3, 0, "wd3_drop");

`ifdef PCI_ARB_PARK_EN
    step(5'b11111, 1, 1, 5'b11110, 1, 3'd0, 0, "park_idle");
    step(5'b01111, 1, 1, 5'b11111, 0, 3'd0, 0, "park_rel");
    step(5'b01111, 1, 1, 5'b01111, 1, 3'd4, 0, "park_next");
`else
    step(5'b11111, 1, 1, 5'b11111, 0, 3'd3, 0, "float_idle");
    step(5'b01111, 1, 1, 5'b01111, 1, 3'd4, 0, "float_next");
`endif

    // Reset in the middle of a transaction drops the grant without a clock edge.
    step(5'b01111, 0, 0, 5'b01111, 1, 3'd4, 0, "m4_busy");
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.gnt",   32'(gnt_n),         32'(5'b11111));
    chk("async_rst.valid", 32'(owner_valid),   32'(0));
    chk("async_rst.owner", 32'(bus_owner),     32'(0));
    chk("async_rst.tmo",   32'(timeout_pulse), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
